// File: rtl/y86_ifetch_pkg.sv
// y86_ifetch_pkg
// Shared constants for the Y86-to-MIPS instruction fetch stage: Y86 opcode
// bytes, MIPS opcode/funct fields, translated-instruction lengths and the
// Y86-to-MIPS register renumbering helper.
package y86_ifetch_pkg;

   localparam logic [7:0] Y86_IRMOVL = 8'h30;
   localparam logic [7:0] Y86_RMMOVL = 8'h40;
   localparam logic [7:0] Y86_MRMOVL = 8'h50;
   localparam logic [7:0] Y86_JMP    = 8'h70;
   localparam logic [7:0] Y86_ADDL   = 8'h60;
   localparam logic [7:0] Y86_NONE   = 8'h00;

   localparam logic [5:0] MIPS_ADDI      = 6'b001000;
   localparam logic [5:0] MIPS_SW        = 6'b101011;
   localparam logic [5:0] MIPS_LW        = 6'b100011;
   localparam logic [5:0] MIPS_J         = 6'b000010;
   localparam logic [5:0] MIPS_RTYPE     = 6'b000000;
   localparam logic [5:0] MIPS_FUNCT_ADD = 6'b100000;

   localparam logic [4:0] LEN_IMM = 5'd24;
   localparam logic [4:0] LEN_JMP = 5'd20;
   localparam logic [4:0] LEN_RR  = 5'd8;
   localparam logic [4:0] LEN_NOP = 5'd4;

   // Y86 register n maps to MIPS register (n+1) mod 16, so MIPS $0 stays free.
   function automatic logic [4:0] mips_reg(input logic [3:0] n);
      return {1'b0, n + 4'd1};
   endfunction

endpackage

// File: rtl/cla32.sv
// cla32
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups with a
// group-level generate/propagate chain. Carry-out is not needed by the fetch
// stage and is not produced.
// Ports:
//   i_a, i_b  operands
//   i_cin     carry in
//   o_sum     i_a + i_b + i_cin (mod 2^32)
module cla32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum
);

   logic [31:0] w_g;
   logic [31:0] w_p;
   logic [7:0]  w_grp_g;
   logic [7:0]  w_grp_p;
   logic [7:0]  w_grp_cin;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Group carries computed through a local accumulator so the chain is not
   // a self-referencing vector.
   always_comb begin
      logic c;
      c         = i_cin;
      w_grp_cin = '0;
      for (int j = 0; j < 8; j++) begin
         w_grp_cin[j] = c;
         c = w_grp_g[j] | (w_grp_p[j] & c);
      end
   end

   for (genvar j = 0; j < 8; j++) begin : g_grp
      logic [3:0] w_gg;
      logic [3:0] w_pp;
      logic [3:0] w_ci;
      logic       w_c0;

      assign w_gg = w_g[4*j +: 4];
      assign w_pp = w_p[4*j +: 4];
      assign w_c0 = w_grp_cin[j];

      assign w_grp_g[j] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                        | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
      assign w_grp_p[j] = &w_pp;

      assign w_ci[0] = w_c0;
      assign w_ci[1] = w_gg[0] | (w_pp[0] & w_c0);
      assign w_ci[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_c0);
      assign w_ci[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                     | (w_pp[2] & w_pp[1] & w_pp[0] & w_c0);

      assign o_sum[4*j +: 4] = w_pp ^ w_ci;
   end

endmodule

// File: rtl/lpm_rom_irom.sv
// lpm_rom_irom
// 64 x 64-bit instruction ROM with a registered read port.
// Ports:
//   i_clk   read-register clock
//   i_rst   synchronous active-high reset, clears the output word
//   i_addr  word address
//   o_q     registered ROM word
// The contents come from the ROM_INIT image loaded by the memory compiler /
// simulation environment; an empty ROM_INIT name yields an all-nop ROM.
module lpm_rom_irom #(
   parameter ROM_INIT = "irom.mif"
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [5:0]  i_addr,
   output logic [63:0] o_q
);

   localparam bit ROM_PRELOADED = (ROM_INIT != '0);

   logic [63:0] r_mem [0:63];
   logic [63:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_q <= '0;
      else
         r_q <= ROM_PRELOADED ? r_mem[i_addr] : '0;
   end

   assign o_q = r_q;

endmodule

// File: rtl/mux4x32.sv
// mux4x32
// 4-input 32-bit multiplexer.
// Ports:
//   i_d0..i_d3  data inputs
//   i_sel       select
//   o_y         selected input
module mux4x32 (
   input  logic [31:0] i_d0,
   input  logic [31:0] i_d1,
   input  logic [31:0] i_d2,
   input  logic [31:0] i_d3,
   input  logic [1:0]  i_sel,
   output logic [31:0] o_y
);

   always_comb begin
      o_y = i_d0;
      case (i_sel)
         2'd0: o_y = i_d0;
         2'd1: o_y = i_d1;
         2'd2: o_y = i_d2;
         2'd3: o_y = i_d3;
         default: o_y = i_d0;
      endcase
   end

endmodule

// File: rtl/y86_ifetch.sv
// y86_ifetch
// Instruction fetch for the Y86-on-MIPS pipeline: reads a 64-bit Y86 word,
// translates it into one MIPS instruction and forms the sequential/next PC.
// Ports:
//   mem_clock  ROM read-register clock
//   reset      synchronous active-high reset (clears the fetched word -> nop)
//   pc         current PC, pc[7:2] addresses the ROM
//   bpc/da/jpc branch, register-indirect and jump targets
//   pcsource   next-PC select (0 pc4, 1 bpc, 2 da, 3 jpc)
//   npc        next PC
//   pc4        pc + translated instruction length
//   ins        translated MIPS instruction
module y86_ifetch
   import y86_ifetch_pkg::*;
#(
   parameter ROM_INIT = "irom.mif"
) (
   input  logic        mem_clock,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] bpc,
   input  logic [31:0] da,
   input  logic [31:0] jpc,
   input  logic [1:0]  pcsource,
   output logic [31:0] npc,
   output logic [31:0] pc4,
   output logic [31:0] ins
);

   logic [63:0] w_y;
   logic [4:0]  w_len;
   logic [31:0] w_ins;
   logic [31:0] w_pc4;
   logic [7:0]  w_op;
   logic        w_unused_y;

   lpm_rom_irom #(
      .ROM_INIT (ROM_INIT)
   ) u_rom (
      .i_clk  (mem_clock),
      .i_rst  (reset),
      .i_addr (pc[7:2]),
      .o_q    (w_y)
   );

   assign w_op       = w_y[47:40];
   assign w_unused_y = ^{w_y[63:48], w_y[23:16]};

   // Translator; first matching rule wins, everything else becomes a nop.
   always_comb begin
      w_ins = '0;
      w_len = LEN_NOP;
      if (w_op == Y86_IRMOVL) begin
         w_ins = {MIPS_ADDI, 5'd0, mips_reg(w_y[35:32]), 8'h00, w_y[31:24]};
         w_len = LEN_IMM;
      end else if (w_op == Y86_RMMOVL) begin
         w_ins = {MIPS_SW, mips_reg(w_y[35:32]), mips_reg(w_y[39:36]), 8'h00, w_y[31:24]};
         w_len = LEN_IMM;
      end else if (w_op == Y86_MRMOVL) begin
         w_ins = {MIPS_LW, mips_reg(w_y[35:32]), mips_reg(w_y[39:36]), 8'h00, w_y[31:24]};
         w_len = LEN_IMM;
      end else if (w_op == Y86_NONE && w_y[39:32] == Y86_JMP) begin
         w_ins = {MIPS_J, 18'd0, w_y[31:24]};
         w_len = LEN_JMP;
      end else if (w_op == Y86_NONE && w_y[15:8] == Y86_ADDL) begin
         w_ins = {MIPS_RTYPE, mips_reg(w_y[3:0]), mips_reg(w_y[7:4]),
                  mips_reg(w_y[3:0]), 5'd0, MIPS_FUNCT_ADD};
         w_len = LEN_RR;
      end
   end

   cla32 u_add (
      .i_a   (pc),
      .i_b   ({27'd0, w_len}),
      .i_cin (1'b0),
      .o_sum (w_pc4)
   );

   mux4x32 u_npc_mux (
      .i_d0  (w_pc4),
      .i_d1  (bpc),
      .i_d2  (da),
      .i_d3  (jpc),
      .i_sel (pcsource),
      .o_y   (npc)
   );

   assign ins = w_ins;
   assign pc4 = w_pc4;

endmodule

// File: tb/tb_y86_ifetch.sv
module tb_y86_ifetch;

   logic        mem_clock = 1'b0;
   logic        reset;
   logic [31:0] pc, bpc, da, jpc;
   logic [1:0]  pcsource;
   logic [31:0] npc, pc4, ins;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] mem_model [64];

   y86_ifetch dut (
      .mem_clock (mem_clock),
      .reset     (reset),
      .pc        (pc),
      .bpc       (bpc),
      .da        (da),
      .jpc       (jpc),
      .pcsource  (pcsource),
      .npc       (npc),
      .pc4       (pc4),
      .ins       (ins)
   );

   always #5 mem_clock = ~mem_clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference translation from the opcode rules, returns {length, ins}.
   function automatic logic [63:0] ref_fetch(input logic [63:0] y);
      int unsigned b_op, b_hi, b_mid, imm, ra, rb, r0, r1;
      int unsigned i_out, len;
      b_op  = (y >> 40) & 'hFF;
      b_hi  = (y >> 32) & 'hFF;
      b_mid = (y >> 8) & 'hFF;
      imm   = (y >> 24) & 'hFF;
      ra    = (((y >> 32) & 'hF) + 1) % 16;
      rb    = (((y >> 36) & 'hF) + 1) % 16;
      r0    = ((y & 'hF) + 1) % 16;
      r1    = (((y >> 4) & 'hF) + 1) % 16;
      if (b_op == 'h30) begin
         i_out = (8 << 26) + (ra << 16) + imm; len = 24;
      end else if (b_op == 'h40) begin
         i_out = (43 << 26) + (ra << 21) + (rb << 16) + imm; len = 24;
      end else if (b_op == 'h50) begin
         i_out = (35 << 26) + (ra << 21) + (rb << 16) + imm; len = 24;
      end else if (b_op == 0 && b_hi == 'h70) begin
         i_out = (2 << 26) + imm; len = 20;
      end else if (b_op == 0 && b_mid == 'h60) begin
         i_out = (r0 << 21) + (r1 << 16) + (r0 << 11) + 32; len = 8;
      end else begin
         i_out = 0; len = 4;
      end
      return {len, i_out};
   endfunction

   function automatic logic [63:0] gen_word();
      logic [63:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0: w[47:40] = 8'h30;
         1: w[47:40] = 8'h40;
         2: w[47:40] = 8'h50;
         3: begin w[47:40] = 8'h00; w[39:32] = 8'h70; end
         4: begin
            w[47:40] = 8'h00;
            if (w[39:32] == 8'h70) w[39:32] = 8'h71;
            w[15:8] = 8'h60;
         end
         default: ;
      endcase
      return w;
   endfunction

   task automatic step();
      @(posedge mem_clock);
      #1;
   endtask

   task automatic check_model(input string tag, input logic [63:0] y);
      logic [63:0] r;
      logic [31:0] e_pc4;
      logic [31:0] sel [4];
      r       = ref_fetch(y);
      e_pc4   = pc + r[63:32];
      sel[0]  = e_pc4; sel[1] = bpc; sel[2] = da; sel[3] = jpc;
      check_val({tag, "_ins"}, ins, r[31:0]);
      check_val({tag, "_pc4"}, pc4, e_pc4);
      check_val({tag, "_npc"}, npc, sel[pcsource]);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_model[i] = gen_word();
      mem_model[4]  = 64'h0000_30F2_0500_0000;
      mem_model[5]  = 64'h0000_4012_0800_0000;
      mem_model[6]  = 64'h0000_5012_0800_0000;
      mem_model[7]  = 64'h0000_0000_0000_6012;
      mem_model[8]  = 64'h0000_0070_4000_0000;
      mem_model[9]  = 64'h0000_30FF_0500_0000;
      mem_model[63] = 64'h0000_0000_0000_0000;
      for (int i = 0; i < 64; i++) dut.u_rom.r_mem[i] = mem_model[i];

      reset = 1'b1; pc = 32'h10; bpc = 32'h100; da = 32'h200; jpc = 32'h300; pcsource = 2'd0;
      step();
      check_val("rst_ins", ins, 32'h0000_0000);
      check_val("rst_pc4", pc4, 32'h14);
      check_val("rst_npc", npc, 32'h14);

      reset = 1'b0;
      step();
      check_val("irmovl_ins", ins, 32'h2003_0005);
      check_val("irmovl_pc4", pc4, 32'h28);

      for (int s = 0; s < 4; s++) begin
         logic [31:0] exp_npc [4];
         exp_npc[0] = 32'h28; exp_npc[1] = 32'h100; exp_npc[2] = 32'h200; exp_npc[3] = 32'h300;
         pcsource = 2'(s);
         step();
         check_val("npc_sel", npc, exp_npc[s]);
      end
      pcsource = 2'd0;

      pc = 32'h14; step();
      check_val("sw_ins", ins, 32'hAC62_0008);
      check_val("sw_pc4", pc4, 32'h14 + 24);
      pc = 32'h18; step();
      check_val("lw_ins", ins, 32'h8C62_0008);
      check_val("lw_pc4", pc4, 32'h18 + 24);
      pc = 32'h1C; step();
      check_val("addl_ins", ins, 32'h0062_1820);
      check_val("addl_pc4", pc4, 32'h1C + 8);
      pc = 32'h20; step();
      check_val("jmp_ins", ins, 32'h0800_0040);
      check_val("jmp_pc4", pc4, 32'h20 + 20);
      pc = 32'h24; step();
      check_val("rt_wrap_ins", ins, 32'h2000_0005);
      pc = 32'hFFFF_FFFC; step();
      check_val("wrap_ins", ins, 32'h0);
      check_val("wrap_pc4", pc4, 32'h0);

      // Reset overrides the ROM read even at an address holding a real opcode.
      reset = 1'b1; pc = 32'h10; step();
      check_val("rst_ovr_ins", ins, 32'h0);
      check_val("rst_ovr_pc4", pc4, 32'h14);
      reset = 1'b0;

      for (int k = 0; k < 300; k++) begin
         logic [63:0] y_exp;
         reset    = ($urandom_range(0, 9) == 0);
         pc       = $urandom;
         bpc      = $urandom;
         da       = $urandom;
         jpc      = $urandom;
         pcsource = 2'($urandom_range(0, 3));
         y_exp    = reset ? 64'h0 : mem_model[pc[7:2]];
         step();
         check_model("rand", y_exp);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
